// File: rtl/qupls_mulu_unit_pkg.sv
// Shared types and decode encodings for the iterative unsigned multiplier unit.
package qupls_mulu_unit_pkg;

  // Sequencer states: waiting for an op, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulu_state_t;

  // Decode encodings that route an op to this unit (mirrored from the decoder).
  localparam logic [6:0] OP_MULUI = 7'd13;
  localparam logic [6:0] FN_MULU  = 7'd16;
  localparam logic [6:0] FN_MULUW = 7'd17;

  // Radix-4 digit width consumed per iteration.
  localparam int unsigned DIGIT_W = 2;

endpackage

// File: rtl/qupls_mulu_unit_step.sv
// One radix-4 partial-product accumulation: prod + digit * mcand.
module qupls_mulu_unit_step
  import qupls_mulu_unit_pkg::*;
#(
  parameter int unsigned WID = 64
) (
  input  logic [2*WID-1:0]   prod,
  input  logic [2*WID-1:0]   mcand,
  input  logic [DIGIT_W-1:0] digit,
  output logic [2*WID-1:0]   next_prod_c
);

  logic [2*WID-1:0] mcand_x2;
  logic [2*WID-1:0] mcand_x3;

  assign mcand_x2 = mcand << 1;
  assign mcand_x3 = mcand + mcand_x2;

  // Select the digit multiple and accumulate; sums wrap at 2*WID bits.
  always_comb begin
    next_prod_c = prod;
    unique case (digit)
      2'd0: next_prod_c = prod;
      2'd1: next_prod_c = prod + mcand;
      2'd2: next_prod_c = prod + mcand_x2;
      2'd3: next_prod_c = prod + mcand_x3;
      default: next_prod_c = prod;
    endcase
  end

endmodule

// File: rtl/qupls_mulu_unit.sv
// Iterative radix-4 unsigned multiplier with issue and writeback handshakes.
module qupls_mulu_unit
  import qupls_mulu_unit_pkg::*;
#(
  parameter int unsigned WID       = 64,
  parameter int unsigned TAGW      = 6,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [WID-1:0]  req_a,
  input  logic [WID-1:0]  req_b,
  input  logic            req_hi,
  input  logic [TAGW-1:0] req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WID-1:0]  resp_res,
  output logic [TAGW-1:0] resp_tag,
  output logic            busy
);

  localparam int unsigned PW    = 2 * WID;
  localparam int unsigned CNT_W = (WID > 2) ? $clog2(WID / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WID / 2 - 1);

  mulu_state_t      state, state_n;
  logic [PW-1:0]    prod, prod_n;
  logic [PW-1:0]    mcand, mcand_n;
  logic [WID-1:0]   mplr, mplr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hi, hi_n;
  logic [TAGW-1:0]  tag, tag_n;
  logic [WID-1:0]   res_n;
  logic [TAGW-1:0]  rtag_n;
  logic [PW-1:0]    step_prod_c;

  qupls_mulu_unit_step #(.WID(WID)) u_step (
    .prod        (prod),
    .mcand       (mcand),
    .digit       (mplr[DIGIT_W-1:0]),
    .next_prod_c (step_prod_c)
  );

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prod       <= '0;
      mcand      <= '0;
      mplr       <= '0;
      cnt        <= '0;
      hi         <= 1'b0;
      tag        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_tag   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      prod       <= prod_n;
      mcand      <= mcand_n;
      mplr       <= mplr_n;
      cnt        <= cnt_n;
      hi         <= hi_n;
      tag        <= tag_n;
      req_ready  <= (state_n == IDLE);
      resp_valid <= (state_n == DONE);
      resp_res   <= res_n;
      resp_tag   <= rtag_n;
      busy       <= (state_n != IDLE);
    end
  end

  // Next-state and datapath update; flush overrides the normal transition.
  always_comb begin
    state_n = state;
    prod_n  = prod;
    mcand_n = mcand;
    mplr_n  = mplr;
    cnt_n   = cnt;
    hi_n    = hi;
    tag_n   = tag;
    res_n   = resp_res;
    rtag_n  = resp_tag;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready && !flush) begin
          mcand_n = {{WID{1'b0}}, req_a};
          mplr_n  = req_b;
          prod_n  = '0;
          cnt_n   = '0;
          hi_n    = req_hi;
          tag_n   = req_tag;
          state_n = RUN;
        end
      end
      RUN: begin
        prod_n  = step_prod_c;
        mcand_n = mcand << DIGIT_W;
        mplr_n  = mplr >> DIGIT_W;
        cnt_n   = cnt + CNT_W'(1);
        // Last digit consumed, or nothing left to add when early-out is on.
        if ((cnt == CNT_LAST) || ((EARLY_OUT != 0) && ((mplr >> DIGIT_W) == '0))) begin
          state_n = DONE;
          res_n   = hi ? step_prod_c[PW-1:WID] : step_prod_c[WID-1:0];
          rtag_n  = tag;
        end
      end
      DONE: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (flush) state_n = IDLE;
  end

endmodule

// File: tb/tb_qupls_mulu_unit.sv
// Directed bench: one unit without early-out, one with it, sharing control inputs.
module tb_qupls_mulu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        resp_ready;
  logic [63:0] req_a, req_b;
  logic        req_hi;
  logic [5:0]  req_tag;

  logic        req_valid0, req_ready0, resp_valid0, busy0;
  logic [63:0] resp_res0;
  logic [5:0]  resp_tag0;
  logic        req_valid1, req_ready1, resp_valid1, busy1;
  logic [63:0] resp_res1;
  logic [5:0]  resp_tag1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qupls_mulu_unit #(.WID(64), .TAGW(6), .EARLY_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .req_hi(req_hi), .req_tag(req_tag),
    .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_res(resp_res0), .resp_tag(resp_tag0), .busy(busy0)
  );

  qupls_mulu_unit #(.WID(64), .TAGW(6), .EARLY_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_hi(req_hi), .req_tag(req_tag),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_res(resp_res1), .resp_tag(resp_tag1), .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for its response; lat counts edges from the accept edge.
  task automatic issue(input bit sel, input logic [63:0] a, input logic [63:0] b,
                       input logic hi, input logic [5:0] tg,
                       output int lat, output logic [63:0] res, output logic [5:0] rtag);
    req_a   = a;
    req_b   = b;
    req_hi  = hi;
    req_tag = tg;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    lat = 1;
    while (!(sel ? resp_valid1 : resp_valid0) && lat < 100) begin
      tick();
      lat++;
    end
    res  = sel ? resp_res1 : resp_res0;
    rtag = sel ? resp_tag1 : resp_tag0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic [5:0]  rtag;
    bit          seen;

    rst = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a = '0; req_b = '0; req_hi = 1'b0; req_tag = '0;

    // Reset values
    tick(); tick();
    check("rst_req_ready", 64'(req_ready0), 64'd0);
    check("rst_resp_valid", 64'(resp_valid0), 64'd0);
    check("rst_resp_res", resp_res0, 64'd0);
    check("rst_resp_tag", 64'(resp_tag0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst_req_ready", 64'(req_ready0), 64'd1);

    // Full-width operands, low and high halves, fixed latency
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'h01, lat, res, rtag);
    check("ff_lo_res", res, 64'h0000_0000_0000_0001);
    check("ff_lo_lat", 64'(lat), 64'd33);
    check("ff_lo_tag", 64'(rtag), 64'h01);
    tick();
    check("ff_lo_idle", 64'(req_ready0), 64'd1);
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h3F, lat, res, rtag);
    check("ff_hi_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check("ff_hi_lat", 64'(lat), 64'd33);
    check("ff_hi_tag", 64'(rtag), 64'h3F);
    tick();

    // Early-out latencies
    issue(1'b1, 64'd7, 64'd5, 1'b0, 6'h2A, lat, res, rtag);
    check("eo_7x5_res", res, 64'd35);
    check("eo_7x5_tag", 64'(rtag), 64'h2A);
    check("eo_7x5_lat", 64'(lat), 64'd3);
    tick();
    issue(1'b1, 64'd123, 64'd0, 1'b0, 6'h05, lat, res, rtag);
    check("eo_b0_res", res, 64'd0);
    check("eo_b0_lat", 64'(lat), 64'd2);
    tick();
    issue(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h10, 1'b0, 6'h06, lat, res, rtag);
    check("eo_shift_res", res, 64'h2345_6789_ABCD_EF00);
    check("eo_shift_lat", 64'(lat), 64'd4);
    tick();
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 6'h07, lat, res, rtag);
    check("eo_hi_res", res, 64'd2);
    check("eo_hi_lat", 64'(lat), 64'd3);
    tick();

    // Backpressure: result held while writeback stalls
    resp_ready = 1'b0;
    issue(1'b1, 64'd3, 64'd4, 1'b0, 6'h11, lat, res, rtag);
    check("bp_lat", 64'(lat), 64'd3);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(resp_valid1), 64'd1);
      check("bp_res", resp_res1, 64'd12);
      check("bp_tag", 64'(resp_tag1), 64'h11);
      check("bp_req_ready", 64'(req_ready1), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release_ready", 64'(req_ready1), 64'd1);
    check("bp_release_valid", 64'(resp_valid1), 64'd0);
    check("bp_release_busy", 64'(busy1), 64'd0);

    // Flush during RUN cycle 5: op vanishes
    req_a = 64'd5; req_b = 64'd6; req_hi = 1'b0; req_tag = 6'h15;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("fl_busy_before", 64'(busy0), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 64'(busy0), 64'd0);
    check("fl_req_ready", 64'(req_ready0), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid0) seen = 1'b1;
      tick();
    end
    check("fl_no_resp", 64'(seen), 64'd0);

    // Flush coincident with a request in IDLE
    flush = 1'b1;
    req_valid0 = 1'b1;
    tick();
    flush = 1'b0;
    req_valid0 = 1'b0;
    check("fl_idle_busy", 64'(busy0), 64'd0);
    check("fl_idle_ready", 64'(req_ready0), 64'd1);
    tick();
    check("fl_idle_busy2", 64'(busy0), 64'd0);

    // Reset mid-RUN
    req_a = 64'd2; req_b = 64'd9; req_tag = 6'h09;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rr_req_ready", 64'(req_ready0), 64'd0);
    check("rr_busy", 64'(busy0), 64'd0);
    check("rr_resp_valid", 64'(resp_valid0), 64'd0);
    check("rr_resp_res", resp_res0, 64'd0);
    check("rr_resp_tag", 64'(resp_tag0), 64'd0);
    rst = 1'b1;
    tick();

    // Reset while holding a response in DONE
    resp_ready = 1'b0;
    issue(1'b1, 64'd10, 64'd10, 1'b0, 6'h22, lat, res, rtag);
    check("rd_res_before", res, 64'd100);
    rst = 1'b0;
    tick();
    check("rd_resp_valid", 64'(resp_valid1), 64'd0);
    check("rd_resp_res", resp_res1, 64'd0);
    check("rd_resp_tag", 64'(resp_tag1), 64'd0);
    check("rd_busy", 64'(busy1), 64'd0);
    check("rd_req_ready", 64'(req_ready1), 64'd0);
    rst = 1'b1;
    resp_ready = 1'b1;
    tick();

    // First ops after reset
    issue(1'b0, 64'd2, 64'd9, 1'b0, 6'h09, lat, res, rtag);
    check("ar0_res", res, 64'd18);
    check("ar0_lat", 64'(lat), 64'd33);
    tick();
    issue(1'b1, 64'd2, 64'd9, 1'b0, 6'h0A, lat, res, rtag);
    check("ar1_res", res, 64'd18);
    check("ar1_lat", 64'(lat), 64'd3);
    check("ar1_tag", 64'(rtag), 64'h0A);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qupls_mulu_unit.md
# qupls_mulu_unit

Iterative radix-4 unsigned multiplier functional unit. It executes every op the decode stage flags as `mulu`: OP_MULUI, and FN_MULU / FN_MULUW under R3B/R3W/R3T/R3O. It sits behind the issue queue and accepts one operation at a time over a valid/ready handshake. It returns the low or high half of the full 2·WID product, tagged with the issuing ROB id, over a second valid/ready handshake toward writeback.

## Interface
Parameters:
- WID, 64, operand width; must be even, so that WID/2 iterations cover all bits.
- TAGW, 6, ROB tag width.
- EARLY_OUT, 1, when 1, iteration stops as soon as the remaining multiplier bits are zero.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- flush  input  1  pipeline flush; aborts any op in flight.
- req_valid  input  1  issue presents an op.
- req_ready  output  1  unit can accept an op.
- req_a  input  WID  multiplicand.
- req_b  input  WID  multiplier; for MULUI, issue supplies the zero-extended immediate here.
- req_hi  input  1  0 returns product[WID-1:0] (FN_MULU, MULUI); 1 returns product[2·WID-1:WID] (FN_MULUW).
- req_tag  input  TAGW  ROB id.
- resp_valid  output  1  result available.
- resp_ready  input  1  writeback accepts the result.
- resp_res  output  WID  selected product half.
- resp_tag  output  TAGW  tag of the result.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid && !flush, capture the op:
    - mcand = {WID'0, req_a} (2·WID bits).
    - mplr = req_b.
    - prod = 0.
    - cnt = 0.
    - hi, tag latched.
  - Go to RUN.
- RUN, each cycle:
  - d = mplr[1:0].
  - prod += d·mcand, where 3·mcand is formed as mcand + (mcand<<1).
  - mcand <<= 2.
  - mplr >>= 2.
  - cnt++.
- Leave RUN for DONE after the iteration where cnt reaches WID/2-1, or, if EARLY_OUT, after the iteration where the post-shift mplr==0.
- Arithmetic: prod is 2·WID bits; all adds are modulo 2^(2·WID), and the exact product never overflows.
- DONE:
  - resp_valid=1.
  - resp_res = hi ? prod[2·WID-1:WID] : prod[WID-1:0].
  - resp_tag = tag.
  - Outputs are held stable until resp_ready=1; that cycle completes the transfer and returns to IDLE.
- Back-to-back ops: req_ready is asserted only in IDLE, so a new op cannot be accepted in the same cycle a response is consumed.
- Flush: in any state, flush=1 forces IDLE on the next edge. Any pending response is dropped without handshake. A req_valid coincident with flush is not accepted.
- Reset (rst=0) overrides flush and every other input, including mid-RUN or mid-DONE.
- Reset values:
  - state=IDLE.
  - req_ready=0 during the reset cycle, then 1.
  - resp_valid=0.
  - resp_res=0.
  - resp_tag=0.
  - busy=0.
  - prod, mcand, mplr and cnt are all 0.

## Timing
- Cycle 0: accept edge (req_valid && req_ready).
- Cycles 1..N: RUN iterations, where N is defined as follows.
  - EARLY_OUT=0: N=WID/2 (32 for WID=64).
  - EARLY_OUT=1: N = max(1, ceil((msb(req_b)+1)/2)); b=0 gives N=1.
- resp_valid rises at the edge ending cycle N, so the result is visible from cycle N+1.
- Accept-to-response latency is N+1 cycles. Minimum issue interval is N+2 cycles when resp_ready is held high.
- req_ready and resp_valid are registered and never both high.

## Structure
- Shared in QuplsPkg:
  - mulu_state_t enum {IDLE, RUN, DONE}.
  - OP_MULUI, FN_MULU and FN_MULUW (already present).
- Natural sub-module: qupls_mulu_step. It is combinational and takes prod, mcand and a 2-bit digit, and returns the next prod. The state machine, counter and handshake stay in the parent.

## Test plan
- WID=64, EARLY_OUT=0, a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, hi=0:
  - Response has res=0x0000_0000_0000_0001.
  - Response arrives exactly 33 cycles after accept.
- Same operands with hi=1 -> res=0xFFFF_FFFF_FFFF_FFFE.
- EARLY_OUT=1:
  - a=7, b=5, tag=0x2A -> res=35, tag=0x2A, latency 3 (N=2).
  - b=0 -> res=0, latency 2.
- Backpressure: a=3, b=4, resp_ready=0 for 10 cycles after resp_valid:
  - res=12 and tag stay stable throughout; req_ready stays 0.
  - Raising resp_ready gives IDLE and req_ready=1 on the next cycle.
- Flush:
  - Flush at RUN cycle 5 -> IDLE next edge, no resp_valid ever appears for that tag.
  - Flush asserted with req_valid in IDLE -> op not accepted, busy stays 0.
- Reset: rst=0 mid-RUN and again in DONE:
  - All outputs return to their reset values on the next edge.
  - The first op issued after reset (a=2, b=9) returns 18.
